instr_decoder: RTL and testbench

INSTR_DECODER -- requirements
Module: instr_decoder

---
 rtl/instr_decoder.sv | 137 +++++++++++++
 tb/tb_instr_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - MIPS instruction decoder with illegal-instruction status
//
// Purpose:
//   Maps a 32-bit MIPS instruction word to a 6-bit instruction code
//   (63 = illegal) combinationally, and keeps a sticky illegal flag and a
//   saturating illegal counter for words qualified by in_valid.
//
// Configuration:
//   INSTR_DECODER_MULDIV_EN - when defined, op=0x00 also decodes the
//   mult/multu/div/divu/mfhi/mflo/mthi/mtlo functs (codes 43..50);
//   otherwise those functs decode as illegal (63).
//
// Ports:
//   clk            in   1  rising-edge clock for the status registers
//   reset          in   1  synchronous, active-high reset
//   instructure_in in  32  instruction word
//   in_valid       in   1  qualifies instructure_in for the status registers
//   instrCode_out  out  6  combinational instruction code
//   illegal        out  1  combinational, high when instrCode_out = 63
//   illegal_sticky out  1  registered, set by any valid illegal word
//   illegal_cnt    out  8  registered saturating count of valid illegal words

module instr_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instructure_in,
  input  logic        in_valid,
  output logic [5:0]  instrCode_out,
  output logic        illegal,
  output logic        illegal_sticky,
  output logic [7:0]  illegal_cnt
);

  localparam logic [5:0] CODE_ILLEGAL = 6'd63;

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic [5:0] code;

  assign op    = instructure_in[31:26];
  assign rt    = instructure_in[20:16];
  assign funct = instructure_in[5:0];

  always_comb begin
    code = CODE_ILLEGAL;
    case (op)
      6'h00: begin
        // An all-zero word is NOP, which would otherwise decode as sll.
        if (instructure_in == 32'h0000_0000) begin
          code = 6'd0;
        end else begin
          case (funct)
            6'h21: code = 6'd1;
            6'h23: code = 6'd2;
            6'h20: code = 6'd3;
            6'h22: code = 6'd4;
            6'h24: code = 6'd5;
            6'h25: code = 6'd6;
            6'h26: code = 6'd7;
            6'h27: code = 6'd8;
            6'h2A: code = 6'd9;
            6'h2B: code = 6'd10;
            6'h00: code = 6'd11;
            6'h02: code = 6'd12;
            6'h03: code = 6'd13;
            6'h04: code = 6'd14;
            6'h06: code = 6'd15;
            6'h07: code = 6'd16;
            6'h08: code = 6'd17;
            6'h09: code = 6'd18;
`ifdef INSTR_DECODER_MULDIV_EN
            6'h18: code = 6'd43;
            6'h19: code = 6'd44;
            6'h1A: code = 6'd45;
            6'h1B: code = 6'd46;
            6'h10: code = 6'd47;
            6'h12: code = 6'd48;
            6'h11: code = 6'd49;
            6'h13: code = 6'd50;
`else
            // mult/div family falls through to the illegal default.
`endif
            default: code = CODE_ILLEGAL;
          endcase
        end
      end
      6'h01: begin
        // REGIMM: only bltz/bgez are supported; rt selects which.
        case (rt)
          5'd0:    code = 6'd31;
          5'd1:    code = 6'd32;
          default: code = CODE_ILLEGAL;
        endcase
      end
      6'h08: code = 6'd19;
      6'h09: code = 6'd20;
      6'h0C: code = 6'd21;
      6'h0D: code = 6'd22;
      6'h0E: code = 6'd23;
      6'h0F: code = 6'd24;
      6'h0A: code = 6'd25;
      6'h0B: code = 6'd26;
      6'h04: code = 6'd27;
      6'h05: code = 6'd28;
      6'h06: code = 6'd29;
      6'h07: code = 6'd30;
      6'h02: code = 6'd33;
      6'h03: code = 6'd34;
      6'h20: code = 6'd35;
      6'h24: code = 6'd36;
      6'h21: code = 6'd37;
      6'h25: code = 6'd38;
      6'h23: code = 6'd39;
      6'h28: code = 6'd40;
      6'h29: code = 6'd41;
      6'h2B: code = 6'd42;
      default: code = CODE_ILLEGAL;
    endcase
  end

  assign instrCode_out = code;
  assign illegal       = (code == CODE_ILLEGAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_sticky <= 1'b0;
      illegal_cnt    <= 8'd0;
    end else if (in_valid && illegal) begin
      illegal_sticky <= 1'b1;
      if (illegal_cnt != 8'hFF) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - scoreboard testbench for instr_decoder
//
// Purpose:
//   Drives directed instruction words with hand-computed codes; each drive
//   pushes the expected outputs into a queue which a negedge monitor pops
//   and compares against the DUT.
//
// Ports: none (top-level bench).

module tb_instr_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] instructure_in;
  logic        in_valid;
  logic [5:0]  instrCode_out;
  logic        illegal;
  logic        illegal_sticky;
  logic [7:0]  illegal_cnt;

  instr_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .instructure_in (instructure_in),
    .in_valid       (in_valid),
    .instrCode_out  (instrCode_out),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky),
    .illegal_cnt    (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  code;
    logic        ill;
    logic        sticky;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic       m_sticky;
  logic [7:0] m_cnt;

`ifdef INSTR_DECODER_MULDIV_EN
  localparam logic [5:0] MULT_CODE = 6'd43;
`else
  localparam logic [5:0] MULT_CODE = 6'd63;
`endif

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (instrCode_out !== e.code) begin
        errors = errors + 1;
        $display("FAIL code word=%h got=%0d exp=%0d", e.word, instrCode_out, e.code);
      end
      checks = checks + 1;
      if (illegal !== e.ill) begin
        errors = errors + 1;
        $display("FAIL illegal word=%h got=%b exp=%b", e.word, illegal, e.ill);
      end
      checks = checks + 1;
      if (illegal_sticky !== e.sticky) begin
        errors = errors + 1;
        $display("FAIL sticky word=%h got=%b exp=%b", e.word, illegal_sticky, e.sticky);
      end
      checks = checks + 1;
      if (illegal_cnt !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL cnt word=%h got=%0d exp=%0d", e.word, illegal_cnt, e.cnt);
      end
    end
  end

  // Drive one word for one cycle; registers are expected at their pre-edge
  // value, then the model advances across the edge.
  task automatic step(input logic [31:0] w, input logic v, input logic r,
                      input logic [5:0] exp_code);
    exp_t e;
    instructure_in = w;
    in_valid       = v;
    reset          = r;
    e.word   = w;
    e.code   = exp_code;
    e.ill    = (exp_code == 6'd63);
    e.sticky = m_sticky;
    e.cnt    = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      m_sticky = 1'b0;
      m_cnt    = 8'd0;
    end else if (v && exp_code == 6'd63) begin
      m_sticky = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic        v;
    logic [5:0]  code;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int waited;
    instructure_in = 32'h0;
    in_valid       = 1'b0;
    reset          = 1'b1;
    m_sticky       = 1'b0;
    m_cnt          = 8'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    vecs.push_back('{32'h0000_0000, 1'b1, 6'd0});
    vecs.push_back('{32'h0002_1080, 1'b1, 6'd11});
    vecs.push_back('{32'h0022_1821, 1'b1, 6'd1});
    vecs.push_back('{32'h0022_1820, 1'b1, 6'd3});
    vecs.push_back('{32'h0022_182A, 1'b1, 6'd9});
    vecs.push_back('{32'h03E0_0008, 1'b1, 6'd17});
    vecs.push_back('{32'h3422_FFFF, 1'b1, 6'd22});
    vecs.push_back('{32'h8C22_0004, 1'b1, 6'd39});
    vecs.push_back('{32'hAC22_0004, 1'b1, 6'd42});
    vecs.push_back('{32'h0C00_0100, 1'b1, 6'd34});
    vecs.push_back('{32'h0800_0000, 1'b1, 6'd33});
    vecs.push_back('{32'h1022_0004, 1'b1, 6'd27});
    vecs.push_back('{32'h0420_0003, 1'b1, 6'd31});
    vecs.push_back('{32'h0421_0003, 1'b1, 6'd32});
    vecs.push_back('{32'h0422_0003, 1'b0, 6'd63});
    vecs.push_back('{32'h0000_0001, 1'b0, 6'd63});
    vecs.push_back('{32'h0000_0000, 1'b1, 6'd0});
    vecs.push_back('{32'h0422_0003, 1'b1, 6'd63});
    vecs.push_back('{32'h0000_0001, 1'b1, 6'd63});
    vecs.push_back('{32'h0022_0018, 1'b1, MULT_CODE});
    vecs.push_back('{32'h2422_0001, 1'b1, 6'd20});

    foreach (vecs[i]) step(vecs[i].word, vecs[i].v, 1'b0, vecs[i].code);

    // Hold an illegal word valid long enough to saturate the counter.
    for (int i = 0; i < 300; i++) step(32'hFC00_0000, 1'b1, 1'b0, 6'd63);
    // Invalid cycles must leave the saturated state untouched.
    for (int i = 0; i < 3; i++) step(32'hFC00_0000, 1'b0, 1'b0, 6'd63);
    // Reset coincident with a valid illegal word wins; code stays live.
    step(32'hFC00_0000, 1'b1, 1'b1, 6'd63);
    step(32'h0000_0000, 1'b0, 1'b0, 6'd0);
    step(32'h0022_1821, 1'b0, 1'b0, 6'd1);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
